scr1_ahb_tb_mem: RTL and testbench
==================================

// Module: scr1_ahb_tb_mem
// PURPOSE
// - Behavioural AHB-Lite slave memory for SCR1 core simulation: one read-only instruction port and one read/write data port.
// - Both ports share a byte-addressed array.
// - Has a memory-mapped console/IRQ block so test programs can print and raise interrupts.
// - Sits in the top-level bench beside the AHB core wrapper; programmable wait-states stress the core's handshakes.
// PARAMETERS
// - SCR1_MEM_POWER_SIZE  16  log2 of RAM size in bytes; addresses wrap modulo 2**SCR1_MEM_POWER_SIZE.
// - SCR1_AHB_WIDTH       32  address/data width (package constant, not overridable).
// - SCR1_IRQ_LINES_NUM   16  external IRQ vector width (package constant; used only with SCR1_IPIC_EN).
// PORTS
// - clk                 in   1   single clock; all logic on its rising edge.
// - rst                 in   1   synchronous active-high reset.
// - irq_lines           out  16  external IRQ lines (SCR1_IPIC_EN only).
// - ext_irq             out  1   external IRQ (no SCR1_IPIC_EN).
// - soft_irq            out  1   software IRQ.
// - imem_req_ack_stall_in in int wait states per imem transfer (0..15; higher values saturate to 15).
// - dmem_req_ack_stall_in in int wait states per dmem transfer (same rule).
// - imem_hsize/htrans   in   3/2 AHB size and trans; haddr in 32.
// - imem_hready out 1; imem_hrdata out 32; imem_hresp out 1 (0=OKAY, 1=ERROR).
// - dmem_hsize/htrans   in   3/2; dmem_haddr in 32; dmem_hwrite in 1; dmem_hwdata in 32.
// - dmem_hready out 1; dmem_hrdata out 32; dmem_hresp out 1.
// BEHAVIOUR
// - Reset values: hready=1, hresp=0, hrdata=0, irq outputs=0, soft_irq=0. RAM contents are not cleared.
// - RAM is a byte array named "memory"; the bench preloads it with $readmemh.
// - Address phase: transfer accepted when htrans[1]=1 (NONSEQ/SEQ) and hready=1. Latch addr, size, write.
// - Port FSM states: IDLE, WAIT, RESP, ERR1, ERR2.
// - IDLE -> WAIT on accept when stall>0; WAIT counts down to 0, holding hready=0; WAIT -> RESP.
// - IDLE -> RESP on accept when stall=0. RESP drives hready=1 with data; a new accept in RESP is pipelined (back-to-back).
// - Zero-stall reads therefore return data the cycle after the address phase.
// - Misaligned transfer (half at addr[0]=1; word at addr[1:0]!=0) or hsize>2 takes the error path:
//   ERR1 drives hready=0, hresp=1; ERR2 drives hready=1, hresp=1.
//   No RAM access. htrans IDLE during ERR2 returns the port to IDLE.
// - Reads: hrdata is the aligned 32-bit word at {addr[31:2],2'b00}, little-endian.
// - Writes: hwdata is sampled in the RESP cycle. hsize 0/1/2 writes 1/2/4 bytes on lanes chosen by addr[1:0].
// - imem port ignores writes; reads only.
// - Same-cycle imem read and dmem write to one word: the imem read returns the pre-write data.
// - MMIO, dmem port only, word access. Outside these addresses, RAM decode ignores addr bits above POWER_SIZE.
//   0xF000_0000 PRINT: write -> $write of hwdata[7:0] as a char; read returns 0.
//   0xF000_0100 IRQ: write sets ext_irq=hwdata[0] (or irq_lines=hwdata[15:0]); read returns current value.
//   0xF000_0200 SOFT_IRQ: write sets soft_irq=hwdata[0]; read returns value.
// - IRQ/soft_irq change the cycle after the write's RESP cycle.
// - Reset asserted mid-transfer: FSM to IDLE next edge; a pending write is discarded.
// CONFIGURATION
// - SCR1_IPIC_EN defined: irq_lines[SCR1_IRQ_LINES_NUM-1:0] is present; IRQ register holds 16 bits.
// - SCR1_IPIC_EN undefined: single ext_irq output; IRQ register holds bit 0 only.
// STRUCTURE
// - Package scr1_ahb_tb_pkg:
//   - HTRANS_IDLE/NONSEQ/SEQ and HSIZE_8/16/32.
//   - HRESP_OKAY/ERROR.
//   - MMIO address constants.
//   - Port FSM state enum.
// - Sub-module scr1_ahb_tb_port:
//   - Implements address latch, stall counter, FSM and hready/hresp generation.
//   - Instantiated once per port; top holds RAM, lane logic and MMIO.
// TESTING
// - Word read, stall 0: memory[0x100..0x103]=78 56 34 12, imem NONSEQ 0x100 -> next cycle hready=1, hrdata=0x12345678.
// - Stall 3: dmem read 0x100 -> hready low 3 cycles, then high with 0x12345678.
// - Byte write: dmem hsize=0 addr 0x101 hwdata=0x0000AB00 -> subsequent word read 0x1234AB78.
// - Misaligned: dmem word at 0x102 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); RAM unchanged.
// - MMIO: write 1 to 0xF000_0200 -> soft_irq=1; write 0x5 to 0xF000_0100 -> irq_lines=0x0005 or ext_irq=1.
// - Reset mid-WAIT: rst during stall -> hready=1, hresp=0 next cycle; pending write not committed.

Source files
------------

// File: rtl/scr1_ahb_tb_pkg.sv
// scr1_ahb_tb_pkg: AHB-Lite encodings, MMIO map and port FSM states for the bench memory
package scr1_ahb_tb_pkg;
  localparam int SCR1_AHB_WIDTH = 32;
  localparam int SCR1_IRQ_LINES_NUM = 16;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_8 = 3'd0, HSIZE_16 = 3'd1, HSIZE_32 = 3'd2;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  localparam logic [31:0] MMIO_PRINT = 32'hF000_0000, MMIO_IRQ = 32'hF000_0100, MMIO_SOFT_IRQ = 32'hF000_0200;
  typedef enum logic [2:0] {PORT_IDLE, PORT_WAIT, PORT_RESP, PORT_ERR1, PORT_ERR2} port_state_e;
endpackage

// File: rtl/scr1_ahb_tb_port.sv
// scr1_ahb_tb_port: AHB-Lite slave handshake - address latch, wait-state counter, error sequencing
import scr1_ahb_tb_pkg::*;
module scr1_ahb_tb_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  output logic        hready,
  output logic        hresp,
  output logic        resp,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        write
);
  port_state_e state;
  logic [3:0] cnt;
  logic accept, misaligned;
  assign accept = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign misaligned = (hsize > HSIZE_32) || (hsize == HSIZE_16 && haddr[0]) || (hsize == HSIZE_32 && |haddr[1:0]);
  assign resp = state == PORT_RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PORT_IDLE;
      hready <= 1'b1;
      hresp <= HRESP_OKAY;
      cnt <= '0;
      addr <= '0;
      size <= '0;
      write <= 1'b0;
    end else if (accept) begin
      addr <= haddr;
      size <= hsize;
      write <= hwrite;
      cnt <= stall - 4'd1;
      state <= misaligned ? PORT_ERR1 : stall == 4'd0 ? PORT_RESP : PORT_WAIT;
      hready <= !misaligned && stall == 4'd0;
      hresp <= misaligned ? HRESP_ERROR : HRESP_OKAY;
    end else begin
      case (state)
        PORT_WAIT: begin
          state <= cnt == 4'd0 ? PORT_RESP : PORT_WAIT;
          hready <= cnt == 4'd0;
          cnt <= cnt - 4'd1;
        end
        PORT_ERR1: begin
          state <= PORT_ERR2;
          hready <= 1'b1;
          hresp <= HRESP_ERROR;
        end
        default: begin
          state <= PORT_IDLE;
          hready <= 1'b1;
          hresp <= HRESP_OKAY;
        end
      endcase
    end
  end
endmodule

// File: rtl/scr1_ahb_tb_mem.sv
// scr1_ahb_tb_mem: dual-port AHB-Lite bench memory with print/IRQ MMIO; SCR1_IPIC_EN widens IRQ to irq_lines
import scr1_ahb_tb_pkg::*;
module scr1_ahb_tb_mem #(
  parameter int SCR1_MEM_POWER_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SCR1_IPIC_EN
  output logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines,
`else
  output logic        ext_irq,
`endif
  output logic        soft_irq,
  input  logic [31:0] imem_req_ack_stall_in,
  input  logic [31:0] dmem_req_ack_stall_in,
  input  logic [2:0]  imem_hsize,
  input  logic [1:0]  imem_htrans,
  input  logic [31:0] imem_haddr,
  output logic        imem_hready,
  output logic [31:0] imem_hrdata,
  output logic        imem_hresp,
  input  logic [2:0]  dmem_hsize,
  input  logic [1:0]  dmem_htrans,
  input  logic [31:0] dmem_haddr,
  input  logic        dmem_hwrite,
  input  logic [31:0] dmem_hwdata,
  output logic        dmem_hready,
  output logic [31:0] dmem_hrdata,
  output logic        dmem_hresp
);
  localparam int P = SCR1_MEM_POWER_SIZE;
  logic [7:0] memory [0:(1 << P) - 1];
  logic i_resp, i_write, d_resp, d_write, d_wr, d_print, d_irq, d_soft, d_mmio, unused_i;
  logic [31:0] i_addr, d_addr, irq_rd;
  logic [2:0] i_size, d_size;
  logic [3:0] lane;
  function automatic logic [3:0] sat(input logic [31:0] s);
    return |s[31:4] ? 4'hF : s[3:0];
  endfunction
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    for (int i = 0; i < 4; i++) rd_word[8*i +: 8] = memory[{a[P-1:2], 2'(i)}];
  endfunction
  scr1_ahb_tb_port u_imem (
    .clk(clk), .rst(rst), .stall(sat(imem_req_ack_stall_in)), .htrans(imem_htrans), .hsize(imem_hsize),
    .haddr(imem_haddr), .hwrite(1'b0), .hready(imem_hready), .hresp(imem_hresp), .resp(i_resp),
    .addr(i_addr), .size(i_size), .write(i_write)
  );
  scr1_ahb_tb_port u_dmem (
    .clk(clk), .rst(rst), .stall(sat(dmem_req_ack_stall_in)), .htrans(dmem_htrans), .hsize(dmem_hsize),
    .haddr(dmem_haddr), .hwrite(dmem_hwrite), .hready(dmem_hready), .hresp(dmem_hresp), .resp(d_resp),
    .addr(d_addr), .size(d_size), .write(d_write)
  );
  assign unused_i = ^{i_addr[31:P], i_size, i_write};
  assign d_print = d_addr == MMIO_PRINT;
  assign d_irq = d_addr == MMIO_IRQ;
  assign d_soft = d_addr == MMIO_SOFT_IRQ;
  assign d_mmio = d_print || d_irq || d_soft;
  assign d_wr = d_resp && d_write;
`ifdef SCR1_IPIC_EN
  assign irq_rd = 32'(irq_lines);
`else
  assign irq_rd = 32'(ext_irq);
`endif
  // Reads are combinational in the data phase, so a write committing at the same edge is not yet visible
  assign imem_hrdata = i_resp ? rd_word(i_addr) : '0;
  assign dmem_hrdata = !(d_resp && !d_write) || d_print ? '0 : d_irq ? irq_rd : d_soft ? 32'(soft_irq) : rd_word(d_addr);
  always_comb lane = d_size == HSIZE_8 ? 4'b0001 << d_addr[1:0] : d_size == HSIZE_16 ? (d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (!rst && d_wr && !d_mmio)
      for (int i = 0; i < 4; i++)
        if (lane[i]) memory[{d_addr[P-1:2], 2'(i)}] <= dmem_hwdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      soft_irq <= 1'b0;
`ifdef SCR1_IPIC_EN
      irq_lines <= '0;
`else
      ext_irq <= 1'b0;
`endif
    end else if (d_wr) begin
      if (d_print) $write("%c", dmem_hwdata[7:0]);
      if (d_soft) soft_irq <= dmem_hwdata[0];
`ifdef SCR1_IPIC_EN
      if (d_irq) irq_lines <= dmem_hwdata[SCR1_IRQ_LINES_NUM-1:0];
`else
      if (d_irq) ext_irq <= dmem_hwdata[0];
`endif
    end
  end
endmodule

// File: tb/tb_scr1_ahb_tb_mem.sv
// tb_scr1_ahb_tb_mem: directed checks of the dual-port AHB bench memory (wait-states, lanes, errors, MMIO, reset)
module tb_scr1_ahb_tb_mem;
  import scr1_ahb_tb_pkg::*;
  logic clk = 1'b0, rst = 1'b1, soft_irq;
  logic [2:0] imem_hsize = HSIZE_32, dmem_hsize = HSIZE_32;
  logic [1:0] imem_htrans = HTRANS_IDLE, dmem_htrans = HTRANS_IDLE;
  logic [31:0] imem_haddr = '0, dmem_haddr = '0, dmem_hwdata = '0, imem_hrdata, dmem_hrdata, irq_obs;
  logic dmem_hwrite = 1'b0, imem_hready, imem_hresp, dmem_hready, dmem_hresp;
  int imem_stall = 0, dmem_stall = 0, n_cmp = 0, n_err = 0;
  logic [31:0] rd;
  int wt;
  logic fr, er;
`ifdef SCR1_IPIC_EN
  logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines;
  localparam logic [31:0] IRQ_EXP = 32'h5;
  assign irq_obs = 32'(irq_lines);
`else
  logic ext_irq;
  localparam logic [31:0] IRQ_EXP = 32'h1;
  assign irq_obs = 32'(ext_irq);
`endif
  always #5 clk = ~clk;
  scr1_ahb_tb_mem dut (
    .clk(clk), .rst(rst),
`ifdef SCR1_IPIC_EN
    .irq_lines(irq_lines),
`else
    .ext_irq(ext_irq),
`endif
    .soft_irq(soft_irq), .imem_req_ack_stall_in(imem_stall), .dmem_req_ack_stall_in(dmem_stall),
    .imem_hsize(imem_hsize), .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hready(imem_hready),
    .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp), .dmem_hsize(dmem_hsize), .dmem_htrans(dmem_htrans),
    .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata), .dmem_hready(dmem_hready),
    .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic dmem_op(input logic [31:0] a, input logic [2:0] sz, input logic w, input logic [31:0] wd,
                         input int st, output logic [31:0] rdata, output int waits, output logic first, output logic err);
    dmem_stall = st;
    dmem_haddr = a;
    dmem_hsize = sz;
    dmem_hwrite = w;
    dmem_htrans = HTRANS_NONSEQ;
    step;
    dmem_htrans = HTRANS_IDLE;
    dmem_hwdata = wd;
    first = dmem_hresp;
    waits = 0;
    while (!dmem_hready && waits < 20) begin
      step;
      waits++;
    end
    rdata = dmem_hrdata;
    err = dmem_hresp;
    step;
  endtask
  task automatic imem_rd(input logic [31:0] a, output logic [31:0] rdata, output int waits);
    imem_haddr = a;
    imem_hsize = HSIZE_32;
    imem_htrans = HTRANS_NONSEQ;
    step;
    imem_htrans = HTRANS_IDLE;
    waits = 0;
    while (!imem_hready && waits < 20) begin
      step;
      waits++;
    end
    rdata = imem_hrdata;
    step;
  endtask
  initial begin
    step;
    step;
    check("rst imem_hready", 32'(imem_hready), 1);
    check("rst dmem_hready", 32'(dmem_hready), 1);
    check("rst hresp", {imem_hresp, dmem_hresp}, 0);
    check("rst imem_hrdata", imem_hrdata, 0);
    check("rst dmem_hrdata", dmem_hrdata, 0);
    check("rst irq", {irq_obs[30:0], soft_irq}, 0);
    rst = 1'b0;
    step;
    dmem_op(32'h100, HSIZE_32, 1'b1, 32'h1234_5678, 0, rd, wt, fr, er);
    check("wr word waits", 32'(wt), 0);
    check("wr word hresp", 32'(er), 0);
    imem_rd(32'h100, rd, wt);
    check("imem stall0 waits", 32'(wt), 0);
    check("imem stall0 data", rd, 32'h1234_5678);
    dmem_op(32'h100, HSIZE_32, 1'b0, 0, 3, rd, wt, fr, er);
    check("dmem stall3 waits", 32'(wt), 3);
    check("dmem stall3 data", rd, 32'h1234_5678);
    dmem_op(32'h100, HSIZE_32, 1'b0, 0, 40, rd, wt, fr, er);
    check("dmem stall sat waits", 32'(wt), 15);
    dmem_op(32'h101, HSIZE_8, 1'b1, 32'h0000_AB00, 0, rd, wt, fr, er);
    dmem_op(32'h100, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("byte write", rd, 32'h1234_AB78);
    dmem_op(32'h102, HSIZE_16, 1'b1, 32'hBEEF_0000, 1, rd, wt, fr, er);
    dmem_op(32'h100, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("half write", rd, 32'hBEEF_AB78);
    dmem_op(32'h102, HSIZE_32, 1'b1, 32'hFFFF_FFFF, 2, rd, wt, fr, er);
    check("misal ERR1 hresp", 32'(fr), 1);
    check("misal ERR1 cycles", 32'(wt), 1);
    check("misal ERR2 hresp", 32'(er), 1);
    dmem_op(32'h100, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("misal ram unchanged", rd, 32'hBEEF_AB78);
    check("okay after err", 32'(er), 0);
    dmem_op(32'h100, 3'd3, 1'b0, 0, 0, rd, wt, fr, er);
    check("hsize3 err", {fr, er}, 32'b11);
    dmem_op(32'h101, HSIZE_16, 1'b0, 0, 0, rd, wt, fr, er);
    check("half misal err", {fr, er}, 32'b11);
    dmem_op(32'h0001_0200, HSIZE_32, 1'b1, 32'hCAFE_F00D, 0, rd, wt, fr, er);
    imem_rd(32'h200, rd, wt);
    check("addr wrap", rd, 32'hCAFE_F00D);
    imem_haddr = 32'h100;
    imem_htrans = HTRANS_NONSEQ;
    step;
    imem_haddr = 32'h200;
    imem_htrans = HTRANS_SEQ;
    check("pipe beat0", {imem_hready, imem_hrdata[30:0]}, {1'b1, 31'h3EEF_AB78});
    step;
    imem_htrans = HTRANS_IDLE;
    check("pipe beat1", imem_hrdata, 32'hCAFE_F00D);
    check("pipe beat1 hready", 32'(imem_hready), 1);
    step;
    check("imem idle hrdata", imem_hrdata, 0);
    imem_haddr = 32'h100;
    imem_htrans = HTRANS_NONSEQ;
    dmem_haddr = 32'h100;
    dmem_hsize = HSIZE_32;
    dmem_hwrite = 1'b1;
    dmem_stall = 0;
    dmem_htrans = HTRANS_NONSEQ;
    step;
    imem_htrans = HTRANS_IDLE;
    dmem_htrans = HTRANS_IDLE;
    dmem_hwdata = 32'h1111_2222;
    check("same-cycle old data", imem_hrdata, 32'hBEEF_AB78);
    step;
    imem_rd(32'h100, rd, wt);
    check("same-cycle new data", rd, 32'h1111_2222);
    dmem_op(MMIO_SOFT_IRQ, HSIZE_32, 1'b1, 32'h1, 0, rd, wt, fr, er);
    check("soft_irq set", 32'(soft_irq), 1);
    dmem_op(MMIO_SOFT_IRQ, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("soft_irq read", rd, 1);
    dmem_op(MMIO_IRQ, HSIZE_32, 1'b1, 32'h5, 0, rd, wt, fr, er);
    check("irq set", irq_obs, IRQ_EXP);
    dmem_op(MMIO_IRQ, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("irq read", rd, IRQ_EXP);
    dmem_op(MMIO_PRINT, HSIZE_32, 1'b1, 32'h41, 0, rd, wt, fr, er);
    dmem_op(MMIO_PRINT, HSIZE_32, 1'b1, 32'h0A, 0, rd, wt, fr, er);
    dmem_op(MMIO_PRINT, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("print read", rd, 0);
    dmem_op(32'h300, HSIZE_32, 1'b1, 32'h0102_0304, 0, rd, wt, fr, er);
    dmem_haddr = 32'h300;
    dmem_hwrite = 1'b1;
    dmem_stall = 5;
    dmem_htrans = HTRANS_NONSEQ;
    step;
    dmem_htrans = HTRANS_IDLE;
    dmem_hwdata = 32'hDEAD_BEEF;
    check("wait hready low", 32'(dmem_hready), 0);
    step;
    rst = 1'b1;
    step;
    check("mid-wait rst hready", 32'(dmem_hready), 1);
    check("mid-wait rst hresp", 32'(dmem_hresp), 0);
    check("mid-wait rst soft_irq", 32'(soft_irq), 0);
    rst = 1'b0;
    step;
    dmem_op(32'h300, HSIZE_32, 1'b0, 0, 0, rd, wt, fr, er);
    check("write discarded", rd, 32'h0102_0304);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
